// File: rtl/sync_updown_counter.sv
// sync_updown_counter: parametrised synchronous up/down counter with a
// programmable modulus, parallel load with clamp, count enable, a terminal-count
// output for cascading and a sticky wrap flag. Every flop uses the single clk.
//
// Compile-time option: define SYNC_UPDOWN_COUNTER_SAT_EN to make the counter
// saturate at 0 / MODULUS-1 instead of wrapping. In this mode wrapped stays 0.
module sync_updown_counter #(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 16,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             zero,
  output logic             wrapped
);

  // Constants in counter width. MODULUS-1 always fits in WIDTH bits, because
  // MODULUS is at most 2**WIDTH.
  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 32'sd1);
  localparam logic [WIDTH-1:0] RST_VAL  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(32'd1);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             wrapped_q;
  logic             wrapped_d;
  logic             at_max;
  logic             at_zero;

  // A load value above the top state is clamped to the top state.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (v > MAX_VAL) begin
      r = MAX_VAL;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // The boundary decodes compare exactly, so the counter never leaves 0..MODULUS-1.
  assign at_max  = (q_q == MAX_VAL);
  assign at_zero = (q_q == ZERO_VAL);

  // Next state: load beats count, count beats hold. Reset is applied in the register.
  always_comb begin
    q_d       = q_q;
    wrapped_d = wrapped_q;
    if (load) begin
      q_d       = clamp_load(d);
      wrapped_d = 1'b0;
    end else if (en) begin
      if (up) begin
        if (at_max) begin
`ifdef SYNC_UPDOWN_COUNTER_SAT_EN
          q_d       = MAX_VAL;
`else
          q_d       = ZERO_VAL;
          wrapped_d = 1'b1;
`endif
        end else begin
          q_d = q_q + ONE_VAL;
        end
      end else begin
        if (at_zero) begin
`ifdef SYNC_UPDOWN_COUNTER_SAT_EN
          q_d       = ZERO_VAL;
`else
          q_d       = MAX_VAL;
          wrapped_d = 1'b1;
`endif
        end else begin
          q_d = q_q - ONE_VAL;
        end
      end
    end else begin
      q_d       = q_q;
      wrapped_d = wrapped_q;
    end
`ifdef SYNC_UPDOWN_COUNTER_SAT_EN
    // Saturation is not wrapping, so the flag can never be set in this mode.
    wrapped_d = 1'b0;
`endif
  end

  // State register. The active-low synchronous reset overrides load and en.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q       <= RST_VAL;
      wrapped_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      wrapped_q <= wrapped_d;
    end
  end

  // tc is combinational, so the next stage of a cascade counts on the same edge
  // on which this stage wraps or saturates.
  assign tc      = en & ~load & ((up & at_max) | (~up & at_zero));
  assign zero    = at_zero;
  assign q       = q_q;
  assign wrapped = wrapped_q;

endmodule

// File: tb/tb_sync_updown_counter.sv
// Bench for sync_updown_counter. It drives four instances from the same stimulus:
//   0: WIDTH=4 MODULUS=10 RESET_VAL=0 (main)
//   1: WIDTH=4 MODULUS=10, cascaded (en = tc of instance 0)
//   2: WIDTH=4 MODULUS=16 RESET_VAL=3 (natural roll-over)
//   3: WIDTH=1 MODULUS=2  RESET_VAL=1 (toggle)
// The reference model works on plain integers with modular arithmetic.
module tb_sync_updown_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] d;

  logic [3:0] q0, q1, q2;
  logic [0:0] q3;
  logic       tc0, tc1, tc2, tc3;
  logic       z0, z1, z2, z3;
  logic       w0, w1, w2, w3;

  localparam int MODS [4] = '{10, 10, 16, 2};
  localparam int RVS  [4] = '{0, 0, 3, 1};

  int mq [4];
  int mw [4];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sync_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_c0 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d),
    .q(q0), .tc(tc0), .zero(z0), .wrapped(w0));

  sync_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_c1 (
    .clk(clk), .rst(rst), .en(tc0), .up(up), .load(load), .d(d),
    .q(q1), .tc(tc1), .zero(z1), .wrapped(w1));

  sync_updown_counter #(.WIDTH(4), .MODULUS(16), .RESET_VAL(3)) u_full (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d),
    .q(q2), .tc(tc2), .zero(z2), .wrapped(w2));

  sync_updown_counter #(.WIDTH(1), .MODULUS(2), .RESET_VAL(1)) u_tog (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d[0:0]),
    .q(q3), .tc(tc3), .zero(z3), .wrapped(w3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Terminal count as the model sees it, for instance i with enable e.
  function automatic bit mtc(int i, bit e);
    return e && !load && ((up && mq[i] == MODS[i] - 1) || (!up && mq[i] == 0));
  endfunction

  // Model the effect of one rising edge on instance i.
  function automatic void model_edge(int i, bit r, bit e, bit u, bit l, int dv);
    int m = MODS[i];
    if (!r) begin
      mq[i] = RVS[i];
      mw[i] = 0;
    end else if (l) begin
      mq[i] = (dv > m - 1) ? m - 1 : dv;
      mw[i] = 0;
    end else if (e) begin
`ifdef SYNC_UPDOWN_COUNTER_SAT_EN
      if (u) mq[i] = (mq[i] + 1 > m - 1) ? m - 1 : mq[i] + 1;
      else   mq[i] = (mq[i] - 1 < 0) ? 0 : mq[i] - 1;
`else
      if (u ? (mq[i] + 1 == m) : (mq[i] == 0)) mw[i] = 1;
      mq[i] = (mq[i] + (u ? 1 : m - 1)) % m;
`endif
    end
  endfunction

  task automatic chk_inst(input int i, input logic [3:0] qo, input logic tco,
                          input logic zo, input logic wo, input bit e);
    chk($sformatf("q%0d", i),       32'(qo),  32'(mq[i]));
    chk($sformatf("tc%0d", i),      32'(tco), 32'(mtc(i, e)));
    chk($sformatf("zero%0d", i),    32'(zo),  32'(mq[i] == 0));
    chk($sformatf("wrapped%0d", i), 32'(wo),  32'(mw[i]));
  endtask

  task automatic check_all();
    bit e1;
    e1 = mtc(0, en);
    chk_inst(0, q0, tc0, z0, w0, en);
    chk_inst(1, q1, tc1, z1, w1, e1);
    chk_inst(2, q2, tc2, z2, w2, en);
    chk_inst(3, {3'b000, q3}, tc3, z3, w3, en);
  endtask

  // Apply inputs, check pre-edge outputs, clock once and advance the model.
  task automatic step(input bit r, input bit e, input bit u, input bit l, input logic [3:0] dv);
    bit ens [4];
    rst = r; en = e; up = u; load = l; d = dv;
    #1;
    check_all();
    ens[0] = e; ens[1] = mtc(0, e); ens[2] = e; ens[3] = e;
    @(posedge clk);
    for (int i = 0; i < 4; i++) model_edge(i, r, ens[i], u, l, (i == 3) ? int'(dv[0]) : int'(dv));
    #1;
  endtask

  initial begin
    // First edge: bring every instance out of the unknown state.
    rst = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; d = 4'd0;
    @(posedge clk);
    for (int i = 0; i < 4; i++) model_edge(i, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    #1;

    // Reset dominates load and en.
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'd7);
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'd7);
    chk("t1_q", 32'(q0), 32'd0);
    chk("t1_zero", 32'(z0), 32'd1);
    chk("t1_wrapped", 32'(w0), 32'd0);
    chk("t1_full_q", 32'(q2), 32'd3);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    chk("t1_hold_q", 32'(q0), 32'd0);

`ifndef SYNC_UPDOWN_COUNTER_SAT_EN
    // Up wrap.
    for (int k = 0; k < 12; k++) step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    chk("t2_q", 32'(q0), 32'd2);
    chk("t2_wrapped", 32'(w0), 32'd1);
    // Down wrap after load of 1.
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'd1);
    chk("t3_wrapped_cleared", 32'(w0), 32'd0);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("t3_q", 32'(q0), 32'd8);
    chk("t3_wrapped", 32'(w0), 32'd1);
    // Load clamp with en also high.
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'd13);
    chk("t4_clamp_q", 32'(q0), 32'd9);
    chk("t4_wrapped", 32'(w0), 32'd0);
    // Cascade: 25 edges from 0.
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
    for (int k = 0; k < 25; k++) step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    chk("t5_stage0", 32'(q0), 32'd5);
    chk("t5_stage1", 32'(q1), 32'd2);
`else
    // Saturating up.
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
    for (int k = 0; k < 12; k++) step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    chk("t6_up_q", 32'(q0), 32'd9);
    chk("t6_up_wrapped", 32'(w0), 32'd0);
    chk("t6_up_tc", 32'(tc0), 32'd1);
    // Saturating down from 2.
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'd2);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("t6_down_q", 32'(q0), 32'd0);
    chk("t6_down_wrapped", 32'(w0), 32'd0);
`endif

    // Randomised traffic checked against the model every cycle.
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 19) != 0),
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) == 0),
           4'($urandom_range(0, 15)));
    end
    rst = 1'b1; en = 1'b0; load = 1'b0;
    #1;
    check_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
